// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control sequencer.
//   - sw_state_t : FSM state encoding, also driven out on the debug LED port
//   - default timing constants for a 50 MHz board clock
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      LAP   = 2'b11
   } sw_state_t;

   // 0.1 s at 50 MHz
   localparam int TICK_DIV_DEFAULT        = 5000000;
   // 20 ms at 50 MHz
   localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

   // Time advances in RUN and LAP; LAP only freezes the display.
   function automatic logic is_running(input sw_state_t s);
      return (s == RUN) || (s == LAP);
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Purpose : 2-flop synchronizer + debounce counter + rising-edge press pulse for one raw button.
// Latency : raw edge held stable -> press pulse 2 + DEBOUNCE_CYCLES cycles later.
// Backpr. : none; press is a single-cycle pulse, release produces no pulse.
// Ports   : clock, reset (sync, active-high), btn_raw (async, active-high), press (1-cycle pulse).
module button_debounce
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_raw,
   output logic press
);

   localparam int              CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          acc_q,   acc_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic          press_q, press_d;

   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      acc_d   = acc_q;
      cnt_d   = '0;
      // Counter only runs while the synchronized level disagrees with the
      // accepted level; any agreeing cycle restarts the stability window.
      if (sync2_q != acc_q) begin
         if (cnt_q == CNT_LAST) begin
            acc_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      // Pulse is registered on the same edge the accepted level rises.
      press_d = acc_d & ~acc_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         acc_q   <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Purpose : stopwatch sequencer - debounced buttons drive a start/pause/lap/clear FSM and a
//           0.1 s prescaler producing count tick, counter clear and display lap-freeze.
// Latency : press pulse -> state and all outputs update on the next clock edge.
// Backpr. : none; buttons are sampled continuously, simultaneous presses resolved by priority.
// Ports   : clock, reset (sync, active-high); btn_start_stop/btn_lap/btn_clear raw buttons;
//           run, tick, clear_count, lap_hold (registered controls); state (2-bit debug encoding).
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV        = TICK_DIV_DEFAULT,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_start_stop,
   input  logic       btn_lap,
   input  logic       btn_clear,
   output logic       run,
   output logic       tick,
   output logic       clear_count,
   output logic       lap_hold,
   output logic [1:0] state
);

   localparam int            PW       = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   logic p_ss, p_lap, p_clr;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
      .clock   (clock),
      .reset   (reset),
      .btn_raw (btn_start_stop),
      .press   (p_ss)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
      .clock   (clock),
      .reset   (reset),
      .btn_raw (btn_lap),
      .press   (p_lap)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
      .clock   (clock),
      .reset   (reset),
      .btn_raw (btn_clear),
      .press   (p_clr)
   );

   sw_state_t     state_q,    state_d;
   logic          run_q,      run_d;
   logic          tick_q,     tick_d;
   logic          clr_q,      clr_d;
   logic          lap_hold_q, lap_hold_d;
   logic [PW-1:0] pre_q,      pre_d;

   // Next-state logic. Within each state presses are tested in priority
   // order clear > start_stop > lap, considering only presses legal there,
   // so an illegal higher-priority press never masks a legal lower one.
   always_comb begin
      state_d = state_q;
      clr_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (p_clr) begin
               clr_d = 1'b1;
            end else if (p_ss) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (p_ss) begin
               state_d = PAUSE;
            end else if (p_lap) begin
               state_d = LAP;
            end
         end
         LAP: begin
            if (p_ss) begin
               state_d = PAUSE;
            end else if (p_lap) begin
               state_d = RUN;
            end
         end
         PAUSE: begin
            if (p_clr) begin
               state_d = IDLE;
               clr_d   = 1'b1;
            end else if (p_ss) begin
               state_d = RUN;
            end
         end
      endcase
      run_d      = is_running(state_d);
      lap_hold_d = (state_d == LAP);
   end

   // Prescaler. Counts every cycle the registered run output is high.
   // If the wrap point coincides with the edge that stops the watch, the
   // count holds at its last value instead of wrapping, so the pending tick
   // is issued on the first cycle after resuming rather than being lost or
   // appearing while run is low.
   always_comb begin
      pre_d  = pre_q;
      tick_d = 1'b0;
      if (clr_d) begin
         pre_d = '0;
      end else if (run_q) begin
         if (pre_q == PRE_LAST) begin
            if (run_d) begin
               pre_d  = '0;
               tick_d = 1'b1;
            end
         end else begin
            pre_d = pre_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         run_q      <= 1'b0;
         tick_q     <= 1'b0;
         clr_q      <= 1'b0;
         lap_hold_q <= 1'b0;
         pre_q      <= '0;
      end else begin
         state_q    <= state_d;
         run_q      <= run_d;
         tick_q     <= tick_d;
         clr_q      <= clr_d;
         lap_hold_q <= lap_hold_d;
         pre_q      <= pre_d;
      end
   end

   assign run         = run_q;
   assign tick        = tick_q;
   assign clear_count = clr_q;
   assign lap_hold    = lap_hold_q;
   assign state       = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=10, DEBOUNCE_CYCLES=4.
// Expected tick cycles are queued as each run interval is started and
// are consumed by a monitor that compares every observed tick against them.
module tb_stopwatch_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] btn   = 3'b000;   // [0]=start_stop [1]=lap [2]=clear
   logic       run, tick, clear_count, lap_hold;
   logic [1:0] state;

   int cyc      = 0;
   int n_checks = 0;
   int n_fail   = 0;
   int exp_ticks[$];

   stopwatch_ctrl #(
      .TICK_DIV        (10),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .btn_start_stop (btn[0]),
      .btn_lap        (btn[1]),
      .btn_clear      (btn[2]),
      .run            (run),
      .tick           (tick),
      .clear_count    (clear_count),
      .lap_hold       (lap_hold),
      .state          (state)
   );

   always #5 clock = ~clock;

   // cyc = number of rising edges so far; sampled on falling edges.
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clock);
   endtask

   // Raise a raw button at the falling edge where cyc == at; it is
   // released 10 cycles later. State reacts at rising edge at+7.
   task automatic press(input int b, input int at);
      wait_cyc(at);
      btn[b] = 1'b1;
      fork
         begin
            repeat (10) @(negedge clock);
            btn[b] = 1'b0;
         end
      join_none
   endtask

   // Tick monitor: every tick must match the head of the expected queue.
   always @(negedge clock) begin
      if (exp_ticks.size() > 0 && exp_ticks[0] < cyc) begin
         check("tick_missed", cyc, exp_ticks[0]);
         void'(exp_ticks.pop_front());
      end
      if (tick === 1'b1) begin
         if (exp_ticks.size() == 0) begin
            check("tick_unexpected", tick, 0);
         end else begin
            check("tick_cycle", cyc, exp_ticks[0]);
            void'(exp_ticks.pop_front());
         end
         check("tick_needs_run", run, 1);
         check("tick_vs_clear", clear_count, 0);
      end
   end

   int n0, r, p, s, u, v;

   initial begin
      // Reset state
      reset = 1'b1;
      repeat (3) @(negedge clock);
      check("rst_run",   run, 0);
      check("rst_tick",  tick, 0);
      check("rst_clr",   clear_count, 0);
      check("rst_lap",   lap_hold, 0);
      check("rst_state", state, 2'b00);
      reset = 1'b0;
      @(negedge clock);

      // Glitches shorter than the debounce window are rejected
      for (int k = 0; k < 5; k++) begin
         btn[0] = 1'b1;
         repeat (3) @(negedge clock);
         btn[0] = 1'b0;
         @(negedge clock);
      end
      repeat (10) @(negedge clock);
      check("glitch_state", state, 2'b00);
      check("glitch_run",   run, 0);

      // Start: state changes exactly 7 edges after the raw rise is driven
      n0 = cyc;
      press(0, n0);
      r = n0 + 7;
      exp_ticks.push_back(r + 10);
      exp_ticks.push_back(r + 20);
      wait_cyc(r - 1);
      check("start_early_state", state, 2'b00);
      wait_cyc(r);
      check("start_state", state, 2'b01);
      check("start_run",   run, 1);
      check("start_lap",   lap_hold, 0);

      // Pause after 25 run cycles; prescaler holds at 5
      press(0, r + 18);
      p = r + 25;
      wait_cyc(p - 1);
      check("pre_pause_state", state, 2'b01);
      wait_cyc(p);
      check("pause_state", state, 2'b10);
      check("pause_run",   run, 0);
      wait_cyc(p + 12);
      check("pause_hold_state", state, 2'b10);

      // Resume: first tick 5 run cycles later, then every 10
      press(0, r + 40);
      s = r + 47;
      for (int k = 0; k < 5; k++) exp_ticks.push_back(s + 5 + 10 * k);
      wait_cyc(s);
      check("resume_state", state, 2'b01);
      check("resume_run",   run, 1);

      // Lap freeze and release; ticks continue throughout
      press(1, s + 2);
      wait_cyc(s + 9);
      check("lap_state", state, 2'b11);
      check("lap_hold",  lap_hold, 1);
      check("lap_run",   run, 1);
      press(1, s + 22);
      wait_cyc(s + 29);
      check("unlap_state", state, 2'b01);
      check("unlap_hold",  lap_hold, 0);

      // Clear is ignored while running
      press(2, s + 30);
      wait_cyc(s + 37);
      check("clr_in_run_pulse", clear_count, 0);
      check("clr_in_run_state", state, 2'b01);

      // Pause, then start_stop and clear together: clear wins
      press(0, s + 40);
      wait_cyc(s + 47);
      check("pause2_state", state, 2'b10);
      press(0, s + 60);
      press(2, s + 60);
      wait_cyc(s + 67);
      check("clr_state", state, 2'b00);
      check("clr_pulse", clear_count, 1);
      check("clr_run",   run, 0);
      wait_cyc(s + 68);
      check("clr_pulse_end", clear_count, 0);

      // Restart from IDLE: cleared prescaler gives a full 10-cycle first tick
      press(0, s + 80);
      u = s + 87;
      exp_ticks.push_back(u + 10);
      wait_cyc(u);
      check("restart_state", state, 2'b01);
      press(1, u + 3);
      wait_cyc(u + 10);
      check("lap2_state", state, 2'b11);
      check("lap2_hold",  lap_hold, 1);

      // Reset in LAP with prescaler at 7
      wait_cyc(u + 17);
      reset = 1'b1;
      @(negedge clock);
      check("mid_rst_state", state, 2'b00);
      check("mid_rst_run",   run, 0);
      check("mid_rst_lap",   lap_hold, 0);
      check("mid_rst_tick",  tick, 0);
      check("mid_rst_clr",   clear_count, 0);
      reset = 1'b0;

      // After reset: full debounce and a full tick period again
      press(0, u + 20);
      v = u + 27;
      exp_ticks.push_back(v + 10);
      wait_cyc(v - 1);
      check("post_rst_early", state, 2'b00);
      wait_cyc(v);
      check("post_rst_state", state, 2'b01);
      wait_cyc(v + 12);
      check("ticks_pending", exp_ticks.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
